// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and types for the width-converting FIFOs
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  typedef logic [DEF_ADDR_WIDTH:0] fifo_level_t;
endpackage

// File: rtl/fifo_n2w_if.sv
// fifo_n2w_if: write/read handshake and status bundle of the narrow-to-wide FIFO
interface fifo_n2w_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                    wr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    rd;
  logic [2*DATA_WIDTH-1:0] r_data;
  logic                    full;
  logic                    empty;
  logic [ADDR_WIDTH:0]     level;
  modport master (output wr, w_data, rd, input r_data, full, empty, level);
  modport slave (input wr, w_data, rd, output r_data, full, empty, level);
endinterface

// File: rtl/fifo_n2w_ctrl.sv
// fifo_n2w_ctrl: pointers, fill level and flags of the narrow-to-wide FIFO
module fifo_n2w_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic [ADDR_WIDTH-1:0] w_ptr,
  output logic [ADDR_WIDTH-1:0] r_ptr,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ok
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic rd_ok;
  assign full  = level == LW'(DEPTH);
  assign empty = level < LW'(2);
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;
  // a read consumes a whole pair, so r_ptr stays even
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + ADDR_WIDTH'(1);
      if (rd_ok) r_ptr <= r_ptr + ADDR_WIDTH'(2);
      level <= level + LW'(wr_ok) - LW'({rd_ok, 1'b0});
    end
endmodule

// File: rtl/fifo_n2w.sv
// fifo_n2w: narrow-to-wide FIFO packing two written words per read, first word low
module fifo_n2w
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic        clk,
  input logic        reset,
  fifo_n2w_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
  logic                  wr_ok;
  fifo_n2w_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) ctrl (
    .clk   (clk),
    .reset (reset),
    .wr    (bus.wr),
    .rd    (bus.rd),
    .w_ptr (w_ptr),
    .r_ptr (r_ptr),
    .level (bus.level),
    .full  (bus.full),
    .empty (bus.empty),
    .wr_ok (wr_ok)
  );
  always_ff @(posedge clk)
    if (wr_ok) mem[w_ptr] <= bus.w_data;
  assign bus.r_data = {mem[r_ptr + ADDR_WIDTH'(1)], mem[r_ptr]};
endmodule
